// File: rtl/mandelbrot_iter_engine_if.sv
// rtl/mandelbrot_iter_engine_if.sv - point request / result handshake bundle for mandelbrot_iter_engine
interface mandelbrot_iter_engine_if #(
  parameter int Q_LEN  = 32,
  parameter int ITER_W = 16
);
  logic                     start;
  logic signed [Q_LEN-1:0]  c_real;
  logic signed [Q_LEN-1:0]  c_imag;
  logic [ITER_W-1:0]        max_iter;
  logic                     busy;
  logic                     result_valid;
  logic                     result_ready;
  logic [ITER_W-1:0]        iter_count;
  logic                     escaped;
  logic signed [Q_LEN-1:0]  z_real_out;
  logic signed [Q_LEN-1:0]  z_imag_out;

  modport master (
    output start, c_real, c_imag, max_iter, result_ready,
    input  busy, result_valid, iter_count, escaped, z_real_out, z_imag_out
  );

  modport slave (
    input  start, c_real, c_imag, max_iter, result_ready,
    output busy, result_valid, iter_count, escaped, z_real_out, z_imag_out
  );
endinterface

// File: rtl/mandelbrot_iter_engine.sv
// rtl/mandelbrot_iter_engine.sv - one-iteration-per-clock Mandelbrot engine; MANDEL_SAT_EN selects saturating z update
module mandelbrot_iter_engine #(
  parameter int Q_LEN    = 32,
  parameter int FRAC_LEN = 28,
  parameter int ITER_W   = 16,
  parameter int BOUND    = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  mandelbrot_iter_engine_if.slave bus
);
  localparam int PW = 2 * Q_LEN;
  localparam int SW = 2 * Q_LEN + 2;
  localparam logic [PW:0] MAG_LIMIT = (PW + 1)'(BOUND) << (2 * FRAC_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                  state;
  logic signed [Q_LEN-1:0] zr, zi, cr, ci;
  logic [ITER_W-1:0]       max_r, n;
  logic                    busy_q, valid_q, esc_q;
  logic [ITER_W-1:0]       count_q;
  logic signed [Q_LEN-1:0] zr_out_q, zi_out_q;

  logic signed [PW-1:0]    zr_x, zi_x, p_rr, p_ii, p_ri;
  logic [PW:0]             mag;
  logic signed [SW-1:0]    rr_x, ii_x, ri2_x, cr_x, ci_x, diff, re_sum, im_sum;
  logic signed [Q_LEN-1:0] re_next, im_next;

  // Narrow the widened next-z sum back to Q_LEN bits.
  function automatic logic signed [Q_LEN-1:0] reduce(input logic signed [SW-1:0] v);
`ifdef MANDEL_SAT_EN
    if (!v[SW-1] && (|v[SW-2:Q_LEN-1]))
      return {1'b0, {(Q_LEN-1){1'b1}}};
    else if (v[SW-1] && !(&v[SW-2:Q_LEN-1]))
      return {1'b1, {(Q_LEN-1){1'b0}}};
    else
      return v[Q_LEN-1:0];
`else
    return v[Q_LEN-1:0];
`endif
  endfunction

  always_comb begin
    zr_x   = {{Q_LEN{zr[Q_LEN-1]}}, zr};
    zi_x   = {{Q_LEN{zi[Q_LEN-1]}}, zi};
    p_rr   = zr_x * zr_x;
    p_ii   = zi_x * zi_x;
    p_ri   = zr_x * zi_x;
    // Squares are non-negative, so the unsigned sum needs only one carry bit.
    mag    = {1'b0, p_rr} + {1'b0, p_ii};
    rr_x   = {{2{p_rr[PW-1]}}, p_rr};
    ii_x   = {{2{p_ii[PW-1]}}, p_ii};
    ri2_x  = {p_ri[PW-1], p_ri, 1'b0};
    cr_x   = {{(SW-Q_LEN){cr[Q_LEN-1]}}, cr};
    ci_x   = {{(SW-Q_LEN){ci[Q_LEN-1]}}, ci};
    diff   = rr_x - ii_x;
    re_sum = (diff >>> FRAC_LEN) + cr_x;
    im_sum = (ri2_x >>> FRAC_LEN) + ci_x;
    re_next = reduce(re_sum);
    im_next = reduce(im_sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      zr       <= '0;
      zi       <= '0;
      cr       <= '0;
      ci       <= '0;
      max_r    <= '0;
      n        <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      esc_q    <= 1'b0;
      count_q  <= '0;
      zr_out_q <= '0;
      zi_out_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            cr     <= bus.c_real;
            ci     <= bus.c_imag;
            max_r  <= bus.max_iter;
            zr     <= '0;
            zi     <= '0;
            n      <= '0;
            busy_q <= 1'b1;
            state  <= S_ITER;
          end
        end
        S_ITER: begin
          if (mag > MAG_LIMIT) begin
            state    <= S_DONE;
            valid_q  <= 1'b1;
            esc_q    <= 1'b1;
            count_q  <= n;
            zr_out_q <= zr;
            zi_out_q <= zi;
          end else if (n == max_r) begin
            state    <= S_DONE;
            valid_q  <= 1'b1;
            esc_q    <= 1'b0;
            count_q  <= max_r;
            zr_out_q <= zr;
            zi_out_q <= zi;
          end else begin
            zr <= re_next;
            zi <= im_next;
            n  <= n + ITER_W'(1);
          end
        end
        S_DONE: begin
          // Result fields stay as they are after the handshake; only the flags drop.
          if (bus.result_ready) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.iter_count   = count_q;
  assign bus.escaped      = esc_q;
  assign bus.z_real_out   = zr_out_q;
  assign bus.z_imag_out   = zi_out_q;
endmodule

// File: doc/mandelbrot_iter_engine.md
# mandelbrot_iter_engine

Sequential, parametrised Mandelbrot iteration engine: accepts one point `c`, iterates `z <- z^2 + c` from `z = 0` at one iteration per clock until escape or an iteration limit, then returns the iteration count, escape flag and final `z` over a valid/ready handshake. It supersedes the purely combinational single-step logic. It keeps full-precision products instead of pre-shifting operands. Several instances sit behind the pixel scheduler, one per compute lane.

## Interface
Parameters:
- `Q_LEN`, 32, total width of signed fixed-point operands
- `FRAC_LEN`, 28, fractional bits (`Q_LEN - FRAC_LEN` integer bits incl. sign)
- `ITER_W`, 16, width of iteration limit and count
- `BOUND`, 4, escape threshold on |z|^2 (integer)

Ports:
- `clk` in 1, single clock, rising edge
- `rst_n` in 1, synchronous active-low reset
- `start` in 1, request to begin a point
- `c_real`, `c_imag` in `Q_LEN`, signed point, sampled on accept
- `max_iter` in `ITER_W`, iteration limit, sampled on accept
- `busy` out 1, high in ITER and DONE
- `result_valid` out 1, result available
- `result_ready` in 1, consumer accepts result
- `iter_count` out `ITER_W`, iterations completed
- `escaped` out 1, 1 = |z|^2 exceeded `BOUND`
- `z_real_out`, `z_imag_out` out `Q_LEN`, `z` at termination

## Operation
- FSM states: IDLE, ITER, DONE.
- Reset (`rst_n` low at an edge, from any state): state IDLE, all outputs 0, internal `z`, `n`, latched `c`/`max_iter` cleared.
- IDLE: `start` high at an edge = accept. Latch `c`, `max_iter`; `z = 0`, `n = 0`; go to ITER.
- ITER, each edge, priority order:
  1. `mag = zr*zr + zi*zi` (full 2*`Q_LEN` products, unsigned sum, 2*`Q_LEN`+1 bits) `> BOUND << (2*FRAC_LEN)`: go to DONE with `escaped = 1` and `iter_count = n`.
  2. Else if `n == max_iter`: go to DONE with `escaped = 0` and `iter_count = max_iter`.
  3. Else `z_real <- (zr*zr - zi*zi) >>> FRAC_LEN + c_real` and `z_imag <- (2*zr*zi) >>> FRAC_LEN + c_imag`; `n <- n + 1`.
- Arithmetic: products signed 2*`Q_LEN`, arithmetic right shift, result reduced to `Q_LEN` per Configuration. Equality with the bound is not escape.
- DONE: `result_valid = 1`; outputs held stable. `result_ready` high at an edge: go to IDLE, `result_valid` drops.
- `start` is ignored in ITER and DONE; no queueing. Neither `start` nor `result_ready` while IDLE has any effect beyond accept.
- `max_iter = 0`: terminates on first ITER edge, `iter_count = 0`, `escaped = 0`.
- `c`/`max_iter` changes after accept have no effect.

## Timing
- Accept edge E0. Termination decision at edge E(k+1), where `k` = final `iter_count`. `result_valid` is high from E(k+1).
- Non-escaping points: `result_valid` high after `max_iter + 1` ITER edges.
- `busy` rises at E0 and falls at the handshake edge. A new `start` is accepted at the earliest on the edge after the handshake edge.
- Minimum turnaround with `result_ready` held high: 3 edges per point for `max_iter = 0`.
- Registered outputs only; no combinational path from inputs to outputs.

## Configuration
- `MANDEL_SAT_EN` defined: reducing each next-`z` sum to `Q_LEN` saturates to the most positive or most negative representable value on overflow.
- `MANDEL_SAT_EN` undefined: two's-complement wrap (truncation of upper bits).
- The escape test is unaffected by the macro in both cases.

## Test plan
All values Q4.28 (`Q_LEN` = 32, `FRAC_LEN` = 28).
- c = 0+0i, max_iter = 100 -> `iter_count` = 100, `escaped` = 0, z_out = 0, `result_valid` 101 edges after accept.
- c = 3.0 (0x30000000)+0i, max_iter = 50 -> `escaped` = 1, `iter_count` = 1, `z_real_out` = 0x30000000.
- c = 2.0 (0x20000000)+0i, max_iter = 50 -> z: 2 (mag 4, no escape), then 6; `escaped` = 1, `iter_count` = 2, `z_real_out` = 0x60000000.
- c = -2.0+0i, max_iter = 10 -> z alternates -2, 2, 2, ..., mag = 4 never > 4; `escaped` = 0, `iter_count` = 10.
- max_iter = 0, any c -> `result_valid` one edge after ITER entry, `iter_count` = 0, `escaped` = 0.
- Handshake/reset:
  - Hold `result_ready` low 5 cycles -> outputs stable and `start` ignored.
  - Pulse `rst_n` low mid-ITER -> all outputs 0 next edge, state IDLE, subsequent start runs cleanly.
